// File: rtl/kronos_pkg.sv
// kronos_pkg: shared types and the watering preset table for kronos_seq.
//   state_t        - sequencer FSM states
//   bcd_t          - one BCD digit
//   mmss_t         - MM:SS display value as four BCD digits (DM,UM,DS,US)
//   preset_lookup  - maps a zone's {T,Ua,H} condition bits to its duration
package kronos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t dm;
        bcd_t um;
        bcd_t ds;
        bcd_t us;
    } mmss_t;

    localparam mmss_t PRESET_0730 = 16'h0730;
    localparam mmss_t PRESET_1500 = 16'h1500;
    localparam mmss_t PRESET_1530 = 16'h1530;
    localparam mmss_t PRESET_2200 = 16'h2200;
    localparam mmss_t PRESET_3000 = 16'h3000;

    // Index is {T, Ua, H}: hot + humid + dry soil waters longest.
    function automatic mmss_t preset_lookup(input logic [2:0] tuh);
        mmss_t p;
        case (tuh)
            3'b000:  p = PRESET_0730;
            3'b001:  p = PRESET_1500;
            3'b010:  p = PRESET_1530;
            3'b011:  p = PRESET_2200;
            3'b100:  p = PRESET_0730;
            3'b101:  p = PRESET_1500;
            3'b110:  p = PRESET_1500;
            default: p = PRESET_3000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// bcd_mmss_down: four-digit MM:SS BCD down-counter.
//   clk_i      - clock
//   rst_i      - synchronous active-high reset (clears to 00:00)
//   clr_i      - synchronous clear to 00:00 (highest priority)
//   load_i     - synchronous load of load_val_i
//   dec_i      - decrement one second with BCD borrow; holds at 00:00
//   load_val_i - value loaded on load_i
//   val_o      - current digits
//   zero_o     - digits read 00:00
module bcd_mmss_down
    import kronos_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clr_i,
    input  logic  load_i,
    input  logic  dec_i,
    input  mmss_t load_val_i,
    output mmss_t val_o,
    output logic  zero_o
);

    mmss_t val_q, val_d, dec_val;

    assign zero_o = (val_q == '0);
    assign val_o  = val_q;

    // Seconds roll 0 -> 59, minutes roll 0 -> 99 style per digit.
    always_comb begin
        dec_val = val_q;
        if (val_q.us != 4'd0) begin
            dec_val.us = val_q.us - 4'd1;
        end else begin
            dec_val.us = 4'd9;
            if (val_q.ds != 4'd0) begin
                dec_val.ds = val_q.ds - 4'd1;
            end else begin
                dec_val.ds = 4'd5;
                if (val_q.um != 4'd0) begin
                    dec_val.um = val_q.um - 4'd1;
                end else begin
                    dec_val.um = 4'd9;
                    dec_val.dm = val_q.dm - 4'd1;
                end
            end
        end
    end

    always_comb begin
        val_d = val_q;
        if (clr_i)                 val_d = '0;
        else if (load_i)           val_d = load_val_i;
        else if (dec_i && !zero_o) val_d = dec_val;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) val_q <= '0;
        else       val_q <= val_d;
    end

endmodule

// File: rtl/kronos_seq.sv
// kronos_seq: irrigation zone sequencer with MM:SS BCD countdown.
//   clk, rst            - clock, synchronous active-high reset
//   start               - pulse, begins a sequence from zone 0 (IDLE, M & ~Error)
//   M, Error            - auto-mode enable, fault; either one aborts a sequence
//   zone_en, T, Ua, H   - per-zone enable mask and condition flags
//   valve               - one-hot open valve (RUN only)
//   zone_idx            - zone being served
//   DM, UM, DS, US      - BCD display digits
//   busy, done          - sequence active, one-cycle completion pulse
//   err_flag            - sticky, set when Error aborts a sequence
module kronos_seq
    import kronos_pkg::*;
#(
    parameter int NZ       = 4,
    parameter int TICK_DIV = 50_000_000,
    localparam int ZW      = (NZ > 1) ? $clog2(NZ) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          M,
    input  logic          Error,
    input  logic [NZ-1:0] zone_en,
    input  logic [NZ-1:0] T,
    input  logic [NZ-1:0] Ua,
    input  logic [NZ-1:0] H,
    output logic [NZ-1:0] valve,
    output logic [ZW-1:0] zone_idx,
    output logic [3:0]    DM,
    output logic [3:0]    UM,
    output logic [3:0]    DS,
    output logic [3:0]    US,
    output logic          busy,
    output logic          done,
    output logic          err_flag
);

    // idx must reach NZ so SCAN can see it has walked past the last zone.
    localparam int IW = $clog2(NZ + 1);
    localparam int PW = $clog2(TICK_DIV);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          err_q, err_d;

    logic          cnt_load, cnt_dec, cnt_clr, cnt_zero;
    mmss_t         cnt_val, preset, disp;
    logic [NZ-1:0] sel;
    logic          th, tick, zone_on;

    assign th      = M & ~Error;
    assign sel     = NZ'(1) << idx_q;           // all-zero once idx_q == NZ
    assign zone_on = |(zone_en & sel);
    assign preset  = preset_lookup({|(T & sel), |(Ua & sel), |(H & sel)});
    assign tick    = (presc_q == PW'(TICK_DIV - 1));

    bcd_mmss_down u_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (preset),
        .val_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            presc_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        presc_d  = presc_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        if (state_q != ST_IDLE && !th) begin
            // Abort outranks everything, including a zone-end tick.
            state_d = ST_IDLE;
            idx_d   = '0;
            presc_d = '0;
            cnt_clr = 1'b1;
            if (Error) err_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && th) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (idx_q >= IW'(NZ)) state_d = ST_DONE;
                    else if (zone_on)     state_d = ST_LOAD;
                    else                  idx_d   = idx_q + IW'(1);
                end
                ST_LOAD: begin
                    cnt_load = 1'b1;
                    presc_d  = '0;
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        // The tick that finds 00:00 ends the zone.
                        if (cnt_zero) begin
                            idx_d   = idx_q + IW'(1);
                            state_d = ST_SCAN;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_DONE: begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The preset is visible during LOAD, before the counter registers it.
    always_comb begin
        disp     = (state_q == ST_LOAD) ? preset : cnt_val;
        valve    = (state_q == ST_RUN) ? sel : '0;
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        err_flag = err_q;
        zone_idx = idx_q[ZW-1:0];
        DM       = disp.dm;
        UM       = disp.um;
        DS       = disp.ds;
        US       = disp.us;
    end

endmodule

// File: tb/tb_kronos_seq.sv
// tb_kronos_seq: directed + randomized check of kronos_seq against a
// seconds-based reference model (NZ=4, TICK_DIV=4).
module tb_kronos_seq;

    localparam int NZ = 4;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          M = 1'b1;
    logic          Error = 1'b0;
    logic [NZ-1:0] zone_en = '0;
    logic [NZ-1:0] T = '0;
    logic [NZ-1:0] Ua = '0;
    logic [NZ-1:0] H = '0;
    logic [NZ-1:0] valve;
    logic [1:0]    zone_idx;
    logic [3:0]    DM, UM, DS, US;
    logic          busy, done, err_flag;

    int n_cmp = 0;
    int n_err = 0;

    // Watering time in seconds, indexed by {T,Ua,H}.
    int psec [8] = '{450, 900, 930, 1320, 450, 900, 900, 1800};

    kronos_seq #(.NZ(NZ), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start(start), .M(M), .Error(Error),
        .zone_en(zone_en), .T(T), .Ua(Ua), .H(H),
        .valve(valve), .zone_idx(zone_idx),
        .DM(DM), .UM(UM), .DS(DS), .US(US),
        .busy(busy), .done(done), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mmss(input int s);
        int m  = s / 60;
        int sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [15:0] dig();
        return {DM, UM, DS, US};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full sequence from IDLE; scramble re-randomises conditions
    // every RUN cycle to show they only matter at LOAD.
    task automatic run_seq(input logic [3:0] en, input logic [3:0] t,
                           input logic [3:0] ua, input logic [3:0] h,
                           input bit scramble);
        int p;
        zone_en = en; T = t; Ua = ua; H = h;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        for (int z = 0; z < NZ; z++) begin
            chk("scan_valve", valve, 0);
            chk("scan_busy", busy, 1);
            step();
            if (en[z]) begin
                p = psec[{T[z], Ua[z], H[z]}];
                chk("load_digits", dig(), mmss(p));
                chk("load_valve", valve, 0);
                step();
                for (int k = 0; k < (p + 1) * TD; k++) begin
                    chk("run_valve", valve, 4'b0001 << z);
                    chk("run_idx", zone_idx, z);
                    chk("run_digits", dig(), mmss(p - k / TD));
                    chk("bcd_range", (DM <= 9 && UM <= 9 && DS <= 5 && US <= 9), 1);
                    if (scramble) begin
                        T = 4'($urandom); Ua = 4'($urandom); H = 4'($urandom);
                    end
                    step();
                end
            end
        end
        chk("end_scan_valve", valve, 0);
        chk("end_scan_done", done, 0);
        step();
        chk("done_pulse", done, 1);
        step();
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_digits", dig(), 0);
        chk("idle_valve", valve, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_valve", valve, 0);
        chk("rst_idx", zone_idx, 0);
        chk("rst_digits", dig(), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_flag, 0);
        rst = 1'b0;
        step();

        // Single zone at 22:00.
        run_seq(4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0);
        // Zones 1 (07:30) and 3 (30:00), skipping 0 and 2; 30:00 crosses 10:00.
        run_seq(4'b1010, 4'b1000, 4'b1000, 4'b1000, 1'b0);
        // No zone enabled: straight to DONE.
        run_seq(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Random mask and conditions, conditions churning during RUN.
        run_seq(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);

        // Error pulse mid-RUN of zone 0.
        zone_en = 4'b0001; T = '0; Ua = '0; H = '0;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        repeat (10) step();
        chk("pre_err_valve", valve, 4'b0001);
        Error = 1'b1; step(); Error = 1'b0;
        chk("abort_valve", valve, 0);
        chk("abort_digits", dig(), 0);
        chk("abort_err", err_flag, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        step();
        chk("err_sticky", err_flag, 1);
        chk("abort_no_done", done, 0);

        // start while Error is high is refused.
        Error = 1'b1; start = 1'b1; step(); start = 1'b0; Error = 1'b0;
        chk("err_start_ignored", busy, 0);

        // Clean restart clears err_flag; then M drops mid-RUN.
        start = 1'b1; step(); start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_err_clr", err_flag, 0);
        step(); step();
        repeat (5) step();
        chk("pre_m_valve", valve, 4'b0001);
        M = 1'b0; step();
        chk("mabort_busy", busy, 0);
        chk("mabort_valve", valve, 0);
        chk("mabort_digits", dig(), 0);
        chk("mabort_err", err_flag, 0);

        // start with M=0 is ignored.
        start = 1'b1; step(); start = 1'b0;
        chk("m0_start_ignored", busy, 0);
        step();
        chk("m0_still_idle", busy, 0);
        M = 1'b1;

        // Reset mid-RUN.
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        repeat (3) step();
        chk("pre_rst_valve", valve, 4'b0001);
        rst = 1'b1; step();
        chk("mrst_valve", valve, 0);
        chk("mrst_digits", dig(), 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_idx", zone_idx, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err_flag, 0);
        rst = 1'b0;
        repeat (3) step();
        chk("mrst_no_resume_busy", busy, 0);
        chk("mrst_no_resume_valve", valve, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kronos_seq.md
# kronos_seq

Parametrised irrigation sequencer and countdown timer for the automatic watering controller. Serves `NZ` zones one after another. For each enabled zone it samples that zone's condition inputs, selects an MM:SS watering duration from a preset table, opens the zone valve, and counts down in BCD at one decrement per second. Its BCD digit outputs drive the 7-segment timer display, and its valve outputs drive the zone solenoids.

## Interface
- `NZ`, 4: number of zones, 1..16.
- `TICK_DIV`, 50_000_000: `clk` cycles per one-second tick, ≥2.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; begins a watering sequence from zone 0.
- `M` in 1: automatic mode enable.
- `Error` in 1: sensor/system fault.
- `zone_en` in `NZ`: per-zone participation mask.
- `T` in `NZ`: per-zone high-temperature flag.
- `Ua` in `NZ`: per-zone air-humidity flag.
- `H` in `NZ`: per-zone soil-dry flag.
- `valve` out `NZ`: one-hot open valve, or all zero.
- `zone_idx` out `$clog2(NZ)` (min 1): zone currently served.
- `DM` out 4: BCD tens of minutes.
- `UM` out 4: BCD units of minutes.
- `DS` out 4: BCD tens of seconds.
- `US` out 4: BCD units of seconds.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `err_flag` out 1: sticky; set when a sequence is aborted by `Error`.

## Operation
- Enable: `TH = M & ~Error`.
  - `start` is accepted only in IDLE with `TH=1`.
  - `start` while busy is ignored.
- Preset table, indexed by `{T,Ua,H}` of the current zone:
  - 000 → 07:30
  - 001 → 15:00
  - 010 → 15:30
  - 011 → 22:00
  - 100 → 07:30
  - 101 → 15:00
  - 110 → 15:00
  - 111 → 30:00
- States: IDLE, SCAN, LOAD, RUN, DONE.
  - IDLE: valves closed, digits 00:00, `busy=0`. Accepted `start` → SCAN with idx=0, and clears `err_flag`.
  - SCAN: examines one zone index per cycle.
    - `zone_en[idx]=1` → LOAD.
    - Otherwise idx+1.
    - Past idx `NZ-1` → DONE.
  - LOAD (1 cycle): latches the preset into the digits, clears the tick prescaler → RUN.
  - RUN:
    - `valve[idx]=1`.
    - Each tick decrements MM:SS in BCD with borrow: US 0→9 borrows DS; DS 0→5 borrows UM; UM 0→9 borrows DM.
    - A tick arriving at 00:00 closes the valve, idx+1 → SCAN.
  - DONE (1 cycle): `done=1` → IDLE.
- Abort:
  - `Error=1` in any non-IDLE state → IDLE next cycle, valves closed, digits 00:00, `err_flag=1`.
  - `M=0` in any non-IDLE state → same response, but `err_flag` is unchanged.
- Condition inputs are sampled only in LOAD; changes during RUN do not alter the running count.
- `zone_en` is sampled in SCAN.

## Timing
- Reset values:
  - all digits 0
  - `valve=0`
  - `zone_idx=0`
  - `busy=0`
  - `done=0`
  - `err_flag=0`
  - state IDLE
  - prescaler 0
- Reset mid-sequence behaves identically: everything returns to the reset values on the next edge.
- `start` at edge n → SCAN at n+1, `busy=1` from n+1.
- Enabled zone found at SCAN cycle s → LOAD at s+1 (digits show the preset) → RUN at s+2 (valve opens).
- The first decrement occurs `TICK_DIV` cycles after RUN entry.
- A zone with preset P seconds keeps its valve open exactly `(P+1)·TICK_DIV` cycles; the extra tick is the 00:00 display second.
- Skipped zones cost 1 cycle each.
- Valves are never simultaneously open; there is at least 2 cycles (SCAN, LOAD) of all-closed between zones.
- If `Error` and a zone-end tick fall in the same cycle, the abort wins.

## Structure
- Package `kronos_pkg` holds:
  - the state enum
  - the BCD digit type (4-bit)
  - the `preset_lookup({T,Ua,H})` function returning 4 digits
  - the preset table constants
- Sub-module `bcd_mmss_down` holds:
  - the four BCD digit registers
  - synchronous `load`, `dec` and `clr` inputs
  - a `zero` output
- The prescaler and FSM stay in `kronos_seq`.

## Test plan
- `TICK_DIV=4`, `NZ=4`. With `zone_en=0001` and zone 0 at `{T,Ua,H}=011`: `start` → digits 22:00 in LOAD, `valve=0001` for 1321·4 cycles, then one `done` pulse and `busy=0`.
- With `zone_en=1010`, zone 1 at 000 and zone 3 at 111: valves open in order 0010 then 1000, with presets 07:30 then 30:00. Zones 0 and 2 are skipped at 1 cycle each, and `zone_idx` reads 1 then 3.
- BCD borrow at 10:00: successive ticks give 09:59, 09:58 … through 09:50 → 09:49. No digit ever exceeds 9, and DS never exceeds 5.
- `Error` pulsed for 1 cycle mid-RUN of zone 0: next cycle all valves closed, digits 00:00, `err_flag=1`, no `done`. A later `start` with `Error=0` clears `err_flag`.
- With `M=0`, `start` is ignored and `busy` stays 0. With `M` dropped during RUN: abort occurs and `err_flag` stays 0.
- `rst` asserted mid-RUN: all outputs return to their reset values on the next edge, and the sequence does not resume.
